// File: rtl/crc32_sched_pkg.sv
// Shared constants, FSM state type and the single-bit CRC-32 update used by
// the frame scheduler and its serial engine.
package crc32_sched_pkg;

    localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One MSB-first, non-reflected CRC step for a single data bit.
    function automatic logic [31:0] crc_bit_step(input logic [31:0] crc_in, input logic bit_in);
        logic fb;
        fb = crc_in[31] ^ bit_in;
        return {crc_in[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/crc32_serial_engine.sv
// Bit-serial CRC-32 remainder register: init reloads the seed, shift_en folds
// in one data bit per clock.
module crc32_serial_engine
    import crc32_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        shift_en,
    input  logic        bit_in,
    output logic [31:0] crc
);

    logic [31:0] crc_r;

    // Remainder register; init takes priority over a shift in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_r <= CRC_INIT;
        end else if (init) begin
            crc_r <= CRC_INIT;
        end else if (shift_en) begin
            crc_r <= crc_bit_step(crc_r, bit_in);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/crc32_frame_sched.sv
// Round-robin scheduler sharing one bit-serial CRC-32 engine among NUM_REQ
// byte streams; a grant is held for a whole frame. Build option
// CRC32_FINAL_XOR_EN selects CRC-32/BZIP2 output, otherwise CRC-32/MPEG-2.
module crc32_frame_sched
    import crc32_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 busy,
    output logic                 crc_valid,
    output logic [31:0]          crc_out,
    output logic [ID_W-1:0]      crc_id
);

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    state_t              state_r;
    logic [ID_W-1:0]     gnt_r;
    logic [ID_W-1:0]     last_grant_r;
    logic [2:0]          bit_cnt_r;
    logic [7:0]          byte_r;
    logic                last_r;
    logic [NUM_REQ-1:0]  ready_r;
    logic                busy_r;
    logic                crc_valid_r;
    logic [31:0]         crc_out_r;
    logic [ID_W-1:0]     crc_id_r;

    logic                pick_found_s;
    logic [ID_W-1:0]     pick_idx_s;
    logic [ID_W-1:0]     cand_s;
    logic                hs_s;
    logic                engine_init_s;
    logic                engine_shift_s;
    logic [31:0]         engine_crc_s;
    logic [31:0]         final_crc_s;
    logic [7:0]          gnt_byte_s;
    logic                gnt_last_s;

    // Round-robin search starting just after the previous frame's owner.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_s = ID_W'((int'(last_grant_r) + off) % NUM_REQ);
            if (!pick_found_s && |(req_valid & onehot(cand_s))) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // ready_r only ever holds the granted bit, so the AND isolates the owner.
    assign hs_s           = |(req_valid & ready_r);
    assign gnt_byte_s     = 8'(req_data >> {gnt_r, 3'b000});
    assign gnt_last_s     = |(req_last & onehot(gnt_r));
    assign engine_init_s  = (state_r == IDLE) && pick_found_s;
    assign engine_shift_s = (state_r == SHIFT);

`ifdef CRC32_FINAL_XOR_EN
    assign final_crc_s = engine_crc_s ^ CRC_XOROUT;
`else
    assign final_crc_s = engine_crc_s;
`endif

    crc32_serial_engine u_engine (
        .clk      (clk),
        .rst      (rst),
        .init     (engine_init_s),
        .shift_en (engine_shift_s),
        .bit_in   (byte_r[7]),
        .crc      (engine_crc_s)
    );

    // Frame FSM: arbitration, byte capture, bit counting and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            gnt_r        <= '0;
            last_grant_r <= ID_W'(NUM_REQ - 1);
            bit_cnt_r    <= 3'd0;
            byte_r       <= 8'h00;
            last_r       <= 1'b0;
            ready_r      <= '0;
            busy_r       <= 1'b0;
            crc_valid_r  <= 1'b0;
            crc_out_r    <= 32'h0000_0000;
            crc_id_r     <= '0;
        end else begin
            crc_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        gnt_r   <= pick_idx_s;
                        ready_r <= onehot(pick_idx_s);
                        busy_r  <= 1'b1;
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    // A stalled requester keeps its grant; the frame is never abandoned.
                    if (hs_s) begin
                        byte_r    <= gnt_byte_s;
                        last_r    <= gnt_last_s;
                        bit_cnt_r <= 3'd0;
                        ready_r   <= '0;
                        state_r   <= SHIFT;
                    end else begin
                        state_r <= LOAD;
                    end
                end
                SHIFT: begin
                    byte_r    <= {byte_r[6:0], 1'b0};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        if (last_r) begin
                            state_r <= DONE;
                        end else begin
                            ready_r <= onehot(gnt_r);
                            state_r <= LOAD;
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    crc_valid_r  <= 1'b1;
                    crc_out_r    <= final_crc_s;
                    crc_id_r     <= gnt_r;
                    last_grant_r <= gnt_r;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    ready_r <= '0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_r;
    assign busy      = busy_r;
    assign crc_valid = crc_valid_r;
    assign crc_out   = crc_out_r;
    assign crc_id    = crc_id_r;

endmodule

// File: tb/tb_crc32_frame_sched.sv
// Scoreboard bench for crc32_frame_sched with four requesters: stimulus queues
// the expected owner order, a monitor checks every crc_valid pulse.
module tb_crc32_frame_sched;

    localparam int NR = 4;
    localparam int IW = 3;
`ifdef CRC32_FINAL_XOR_EN
    localparam logic [31:0] EXP_CRC = 32'hFC89_1918;
`else
    localparam logic [31:0] EXP_CRC = 32'h0376_E6E7;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            busy;
    logic            crc_valid;
    logic [31:0]     crc_out;
    logic [IW-1:0]   crc_id;

    logic            v [NR];
    logic [7:0]      d [NR];
    logic            l [NR];
    logic [7:0]      msg [9];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_hs [NR];
    int exp_q [$];
    int mon_id;

    crc32_frame_sched #(.NUM_REQ(NR), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .busy      (busy),
        .crc_valid (crc_valid),
        .crc_out   (crc_out),
        .crc_id    (crc_id)
    );

    for (genvar g = 0; g < NR; g++) begin : g_drv
        assign req_valid[g]       = v[g];
        assign req_data[8*g +: 8] = d[g];
        assign req_last[g]        = l[g];
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: each result pulse pops the next expected owner.
    always @(negedge clk) begin
        if (rst && crc_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_crc_valid", crc_valid, 1'b0);
            end else begin
                mon_id = exp_q.pop_front();
                check("crc_out", crc_out, EXP_CRC);
                check("crc_id", crc_id, mon_id);
                check("latency", cyc - last_hs[mon_id], 9);
            end
        end
    end

    // Grant must never cover more than one requester.
    always @(negedge clk) begin
        if (rst) check("ready_onehot0", $onehot0(req_ready), 1'b1);
    end

    task automatic send(input int r, input int nbytes, input bit flag_last, input int gap_at);
        int t;
        for (int i = 0; i < nbytes; i++) begin
            if (i == gap_at) begin
                @(negedge clk);
                v[r] = 1'b0;
                repeat (20) @(negedge clk);
                check("gap_ready_held", req_ready, NR'(1) << r);
                check("gap_busy", busy, 1'b1);
            end
            @(negedge clk);
            v[r] = 1'b1;
            d[r] = msg[i];
            l[r] = flag_last && (i == nbytes - 1);
            t = 0;
            while (!req_ready[r] && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 3000) check("ready_timeout", req_ready[r], 1'b1);
            @(posedge clk);
            #1;
            last_hs[r] = cyc;
        end
        @(negedge clk);
        v[r] = 1'b0;
        l[r] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, req_ready, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_crc_valid"}, crc_valid, 1'b0);
        check({tag, "_crc_out"}, crc_out, 32'h0);
        check({tag, "_crc_id"}, crc_id, '0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
        for (int i = 0; i < NR; i++) begin
            v[i] = 1'b0; d[i] = 8'h00; l[i] = 1'b0; last_hs[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b1;

        // Single frame on requester 0.
        exp_q.push_back(0);
        send(0, 9, 1'b1, -1);
        check("busy_in_frame", busy, 1'b1);
        drain();
        check("busy_after", busy, 1'b0);

        // Two contenders from reset, requester 0 re-requests right after its result.
        pulse_reset();
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(0);
        fork
            begin
                send(0, 9, 1'b1, -1);
                send(0, 9, 1'b1, -1);
            end
            send(1, 9, 1'b1, -1);
        join
        drain();

        // Valid gap mid-frame: grant and remainder are preserved.
        exp_q.push_back(0);
        send(0, 9, 1'b1, 4);
        drain();

        // Reset during SHIFT of byte 4, then a clean frame.
        send(0, 4, 1'b0, -1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        exp_q.push_back(0);
        send(0, 9, 1'b1, -1);
        drain();

        // Make requester 2 the last owner, then all four contend: order 3,0,1,2.
        exp_q.push_back(2);
        send(2, 9, 1'b1, -1);
        drain();
        exp_q.push_back(3);
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        fork
            send(0, 9, 1'b1, -1);
            send(1, 9, 1'b1, -1);
            send(2, 9, 1'b1, -1);
            send(3, 9, 1'b1, -1);
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crc32_frame_sched.md
Name: crc32_frame_sched

Overview:
Round-robin scheduler that shares one bit-serial CRC-32 engine among NUM_REQ byte-stream requesters.
- A grant is held for a whole frame, from the first byte to the byte flagged last.
- Each byte is fed MSB-first through the engine, one bit per clk.
- The 32-bit remainder is returned tagged with the owning requester's index.
- Sits between the packet sources and the frame-check append/compare logic.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 3, width of crc_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  per-requester last-byte-of-frame flag.
- req_ready  out  NUM_REQ  byte accepted when req_valid[i] & req_ready[i].
- busy  out  1  high from grant until crc_valid.
- crc_valid  out  1  one-cycle pulse; frame result available.
- crc_out  out  32  CRC of the finished frame.
- crc_id  out  ID_W  index of the requester that owned the frame.

Behaviour:
- CRC definition:
  - poly 0x04C11DB7, init 0xFFFFFFFF.
  - No reflection; data bit 7 is processed first.
  - Per-bit update: fb = crc[31] ^ bit; crc = {crc[30:0],1'b0} ^ (fb ? POLY : 0).
- States: IDLE, LOAD, SHIFT, DONE. Registered state, 3-bit bit counter, grant register, last-grant pointer.
- IDLE:
  - If any req_valid, grant the first valid requester searching from (last_grant+1) mod NUM_REQ, with wrap-around.
  - Set crc to CRC_INIT and go to LOAD.
  - If no req_valid, stay in IDLE.
- LOAD:
  - req_ready[gnt]=1; every other req_ready bit is 0.
  - On handshake: capture byte and last flag, clear bit counter, go to SHIFT.
  - No handshake: hold in LOAD indefinitely. The grant is kept and crc is untouched; the frame is not abandoned.
- SHIFT:
  - Applies one bit per cycle for exactly 8 cycles.
  - After the 8th bit: if the captured last flag was set go to DONE, else go to LOAD.
- DONE:
  - crc_valid=1, crc_out = final value, crc_id = gnt, for exactly one cycle.
  - last_grant <= gnt; go to IDLE.
- Throughput and latency:
  - At most 1 byte per 9 cycles (1 LOAD + 8 SHIFT).
  - crc_valid rises 9 cycles after the last byte's handshake edge.
  - A new grant can occur no earlier than the cycle after DONE.
- req_ready is a function of registered state only; it has no combinational path from req_valid.
- Simultaneous requests: round-robin as above. After reset last_grant = NUM_REQ-1, so requester 0 wins first.
- Frame length: 1 byte minimum. Zero-length frames are impossible because req_last qualifies a byte.
- Outside DONE, crc_out holds its last value and crc_id holds its last value.
- Reset (also mid-frame, any state):
  - state=IDLE; req_ready=0, busy=0, crc_valid=0.
  - crc_out=0, crc_id=0, crc=0xFFFFFFFF, last_grant=NUM_REQ-1.
  - The in-flight frame is discarded with no result pulse.

Optional Feature:
- CRC32_FINAL_XOR_EN defined: crc_out = remainder ^ 0xFFFFFFFF (CRC-32/BZIP2). Check value for "123456789" is 0xFC891918.
- Not defined: crc_out = raw remainder (CRC-32/MPEG-2). Check value is 0x0376E6E7.
- Nothing else changes: timing and ports are identical in both builds.

Decomposition:
- Package crc32_sched_pkg:
  - CRC_POLY=32'h04C11DB7, CRC_INIT=32'hFFFFFFFF, CRC_XOROUT=32'hFFFFFFFF.
  - State enum {IDLE,LOAD,SHIFT,DONE}.
- Sub-module crc32_serial_engine:
  - Ports clk, rst, init, shift_en, bit_in, crc[31:0].
  - init loads CRC_INIT; shift_en applies one bit.
  - The scheduler owns arbitration, byte capture, bit counter and output registers.

Test Plan:
- Frame "123456789" (0x31..0x39, last on 0x39) on req 0 only -> crc_valid one pulse, crc_out=0x0376E6E7 (0xFC891918 with CRC32_FINAL_XOR_EN), crc_id=0; 9 cycles from the last handshake to crc_valid.
- req 0 and req 1 both valid from reset, each sending "123456789" -> req 0 frame completes first with crc_id=0, then req 1 with crc_id=1; both crc_out=0x0376E6E7; no byte interleaving.
- Fairness: req 0 re-asserts immediately after its DONE while req 1 is waiting -> req 1 granted next.
- req_valid gaps: requester drops valid for 20 cycles mid-frame -> scheduler holds LOAD, other requesters stay unready, final CRC still 0x0376E6E7.
- rst asserted during SHIFT of byte 4 -> all outputs reset values, no crc_valid. A subsequent full frame then yields the correct CRC.
- NUM_REQ=4, all valid, last_grant=2 -> grant order 3,0,1,2.
